// File: rtl/map104_bank_ctrl_pkg.sv
// Shared definitions for the mapper 104 PRG bank controller: sequencer states,
// CPU decode masks and save-state byte layout.
package map104_bank_ctrl_pkg;

  localparam logic [2:0] ST_IDLE_V   = 3'd0;
  localparam logic [2:0] ST_XFER_V   = 3'd1;
  localparam logic [2:0] ST_CHECK_V  = 3'd2;
  localparam logic [2:0] ST_COMMIT_V = 3'd3;
  localparam logic [2:0] ST_DONE_V   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_V,
    ST_XFER   = ST_XFER_V,
    ST_CHECK  = ST_CHECK_V,
    ST_COMMIT = ST_COMMIT_V,
    ST_DONE   = ST_DONE_V
  } ss_state_e;

  localparam logic [15:0] DEC_MASK  = 16'hC000;
  localparam logic [15:0] DEC_OUTER = 16'h8000;

  localparam logic [7:0] SS_IDX_BANK = 8'd0;
  localparam logic [7:0] SS_IDX_MAP  = 8'd1;

  // Register target of a CPU write, as held in the pending buffer.
  localparam logic TGT_OUTER = 1'b0;
  localparam logic TGT_INNER = 1'b1;

endpackage

// File: rtl/map104_bank_ctrl_wr_pend.sv
// One-entry buffer for CPU bank writes that arrive while the save-state
// sequencer is busy; a newer write replaces the older one and flags it.
module map_wr_pend (
  input  logic       m2,
  input  logic       map_rst,
  input  logic       cap_vld,
  input  logic       cap_tgt,
  input  logic [3:0] cap_dat,
  input  logic       drain,
  output logic       pend_vld,
  output logic       pend_tgt,
  output logic [3:0] pend_dat,
  output logic       wr_ovf
);

  logic       vld_q, vld_d;
  logic       tgt_q, tgt_d;
  logic [3:0] dat_q, dat_d;
  logic       ovf_q, ovf_d;

  always_comb begin
    vld_d = vld_q;
    tgt_d = tgt_q;
    dat_d = dat_q;
    ovf_d = ovf_q;
    if (cap_vld) begin
      vld_d = 1'b1;
      tgt_d = cap_tgt;
      dat_d = cap_dat;
      if (vld_q) ovf_d = 1'b1;
    end
    if (drain) vld_d = 1'b0;
  end

  always_ff @(negedge m2) begin
    if (map_rst) begin
      vld_q <= 1'b0;
      tgt_q <= 1'b0;
      dat_q <= 4'h0;
      ovf_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      tgt_q <= tgt_d;
      dat_q <= dat_d;
      ovf_q <= ovf_d;
    end
  end

  // A write captured on the drain edge itself is the newest one, so it wins.
  assign pend_vld = vld_q | cap_vld;
  assign pend_tgt = cap_vld ? cap_tgt : tgt_q;
  assign pend_dat = cap_vld ? cap_dat : dat_q;
  assign wr_ovf   = ovf_q;

endmodule

// File: rtl/map104_bank_ctrl.sv
// PRG outer/inner bank registers with lock, CPU write decode, and a save-state
// sequencer that dumps/restores the register image over a valid/ready channel.
module map104_bank_ctrl
  import map104_bank_ctrl_pkg::*;
#(
  parameter logic [7:0] MAP_IDX  = 8'd104,
  parameter int         SS_BYTES = 2
) (
  input  logic        m2,
  input  logic        map_rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dat,
  input  logic        cpu_rw,
  input  logic        ss_start,
  input  logic        ss_dir,
  output logic        ss_valid,
  input  logic        ss_ready,
  output logic [7:0]  ss_idx,
  output logic [7:0]  ss_wdat,
  input  logic [7:0]  ss_rdat,
  output logic        ss_busy,
  output logic        ss_done,
  output logic        ss_err,
  output logic        wr_ovf,
  output logic [3:0]  prg_ou,
  output logic [3:0]  prg_in,
  output logic [6:0]  prg_hi
);

  // Byte channel: a byte moves on any m2 falling edge where ss_valid and
  // ss_ready are both high; ss_valid stays up and ss_idx holds until then.
  localparam logic [7:0] LAST_IDX = 8'(SS_BYTES - 1);

  ss_state_e  state_q, state_d;
  logic       dir_q, dir_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] stage_q, stage_d;
  logic [7:0] id_stage_q, id_stage_d;
  logic       err_q, err_d;
  logic [3:0] prg_ou_q, prg_ou_d;
  logic [3:0] prg_in_q, prg_in_d;

  logic       busy;
  logic       dec_outer, dec_inner, dec_vld;
  logic       pend_vld, pend_tgt;
  logic [3:0] pend_dat;
  logic       drain;
  logic       wr_en, wr_tgt;
  logic [3:0] wr_dat;

  assign busy      = (state_q != ST_IDLE);
  assign dec_outer = !cpu_rw && ((cpu_addr & DEC_MASK) == DEC_OUTER);
  assign dec_inner = !cpu_rw && ((cpu_addr & DEC_MASK) == DEC_MASK);
  assign dec_vld   = dec_outer | dec_inner;
  assign drain     = (state_q == ST_DONE);

  map_wr_pend u_pend (
    .m2       (m2),
    .map_rst  (map_rst),
    .cap_vld  (busy & dec_vld),
    .cap_tgt  (dec_inner),
    .cap_dat  (cpu_dat[3:0]),
    .drain    (drain),
    .pend_vld (pend_vld),
    .pend_tgt (pend_tgt),
    .pend_dat (pend_dat),
    .wr_ovf   (wr_ovf)
  );

  // Register write source: direct CPU write when idle, pending write on the
  // edge that leaves DONE (so it lands after any restore commit).
  always_comb begin
    wr_en  = 1'b0;
    wr_tgt = TGT_OUTER;
    wr_dat = 4'h0;
    if (!busy) begin
      wr_en  = dec_vld;
      wr_tgt = dec_inner;
      wr_dat = cpu_dat[3:0];
    end else if (drain) begin
      wr_en  = pend_vld;
      wr_tgt = pend_tgt;
      wr_dat = pend_dat;
    end
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    idx_d      = idx_q;
    stage_d    = stage_q;
    id_stage_d = id_stage_q;
    err_d      = err_q;
    prg_ou_d   = prg_ou_q;
    prg_in_d   = prg_in_q;

    if (wr_en) begin
      if (wr_tgt == TGT_INNER) prg_in_d = wr_dat;
      else if (!prg_ou_q[3])   prg_ou_d = wr_dat;
    end

    case (state_q)
      ST_IDLE: begin
        if (ss_start) begin
          state_d = ST_XFER;
          idx_d   = 8'd0;
          dir_d   = ss_dir;
          if (ss_dir) err_d = 1'b0;
        end
      end
      ST_XFER: begin
        if (ss_ready) begin
          if (dir_q) begin
            if (idx_q == SS_IDX_BANK) stage_d    = ss_rdat;
            if (idx_q == SS_IDX_MAP)  id_stage_d = ss_rdat;
          end
          idx_d = idx_q + 8'd1;
          if (idx_q == LAST_IDX) state_d = dir_q ? ST_CHECK : ST_DONE;
        end
      end
      ST_CHECK: begin
        if (id_stage_q == MAP_IDX) begin
          state_d = ST_COMMIT;
        end else begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_COMMIT: begin
        // Restored image bypasses the outer lock.
        prg_in_d = stage_q[7:4];
        prg_ou_d = stage_q[3:0];
        state_d  = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge m2) begin
    if (map_rst) begin
      state_q    <= ST_IDLE;
      dir_q      <= 1'b0;
      idx_q      <= 8'd0;
      stage_q    <= 8'd0;
      id_stage_q <= 8'd0;
      err_q      <= 1'b0;
      prg_ou_q   <= 4'h0;
      prg_in_q   <= 4'h0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      idx_q      <= idx_d;
      stage_q    <= stage_d;
      id_stage_q <= id_stage_d;
      err_q      <= err_d;
      prg_ou_q   <= prg_ou_d;
      prg_in_q   <= prg_in_d;
    end
  end

  always_comb begin
    ss_wdat = 8'hFF;
    if (idx_q == SS_IDX_BANK)     ss_wdat = {prg_in_q, prg_ou_q};
    else if (idx_q == SS_IDX_MAP) ss_wdat = MAP_IDX;
  end

  assign ss_valid = (state_q == ST_XFER);
  assign ss_busy  = busy;
  assign ss_done  = (state_q == ST_DONE);
  assign ss_idx   = idx_q;
  assign ss_err   = err_q;
  assign prg_ou   = prg_ou_q;
  assign prg_in   = prg_in_q;
  assign prg_hi   = {prg_ou_q[2:0], cpu_addr[14] ? 4'hF : prg_in_q};

endmodule

// File: tb/tb_map104_bank_ctrl.sv
// Directed bench for map104_bank_ctrl: CPU decode and lock, dump, good/bad
// restore, pending-write arbitration and reset during a transfer.
module tb_map104_bank_ctrl;

  logic        m2 = 1'b1;
  logic        map_rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dat;
  logic        cpu_rw;
  logic        ss_start;
  logic        ss_dir;
  logic        ss_valid;
  logic        ss_ready;
  logic [7:0]  ss_idx;
  logic [7:0]  ss_wdat;
  logic [7:0]  ss_rdat;
  logic        ss_busy;
  logic        ss_done;
  logic        ss_err;
  logic        wr_ovf;
  logic [3:0]  prg_ou;
  logic [3:0]  prg_in;
  logic [6:0]  prg_hi;

  int n_checks = 0;
  int n_errors = 0;

  map104_bank_ctrl dut (
    .m2       (m2),
    .map_rst  (map_rst),
    .cpu_addr (cpu_addr),
    .cpu_dat  (cpu_dat),
    .cpu_rw   (cpu_rw),
    .ss_start (ss_start),
    .ss_dir   (ss_dir),
    .ss_valid (ss_valid),
    .ss_ready (ss_ready),
    .ss_idx   (ss_idx),
    .ss_wdat  (ss_wdat),
    .ss_rdat  (ss_rdat),
    .ss_busy  (ss_busy),
    .ss_done  (ss_done),
    .ss_err   (ss_err),
    .wr_ovf   (wr_ovf),
    .prg_ou   (prg_ou),
    .prg_in   (prg_in),
    .prg_hi   (prg_hi)
  );

  // Clock / reset
  always #5 m2 = ~m2;

  // State updates on the falling edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(negedge m2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic do_reset();
    map_rst = 1'b1;
    tick();
    tick();
    map_rst = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a;
    cpu_dat  = d;
    cpu_rw   = 1'b0;
    tick();
    cpu_rw   = 1'b1;
  endtask

  task automatic start_xfer(input logic dir);
    ss_start = 1'b1;
    ss_dir   = dir;
    tick();
    ss_start = 1'b0;
  endtask

  task automatic check_banks(input string tag, input logic [3:0] ou, input logic [3:0] inr);
    chk({tag, "_ou"}, 8'(prg_ou), 8'(ou));
    chk({tag, "_in"}, 8'(prg_in), 8'(inr));
  endtask

  task automatic check_reset_vals(input string tag);
    check_banks(tag, 4'h0, 4'h0);
    chk({tag, "_busy"},  8'(ss_busy),  8'h0);
    chk({tag, "_valid"}, 8'(ss_valid), 8'h0);
    chk({tag, "_idx"},   ss_idx,       8'h0);
    chk({tag, "_done"},  8'(ss_done),  8'h0);
    chk({tag, "_err"},   8'(ss_err),   8'h0);
    chk({tag, "_ovf"},   8'(wr_ovf),   8'h0);
  endtask

  initial begin
    map_rst  = 1'b1;
    cpu_addr = 16'h0000;
    cpu_dat  = 8'h00;
    cpu_rw   = 1'b1;
    ss_start = 1'b0;
    ss_dir   = 1'b0;
    ss_ready = 1'b0;
    ss_rdat  = 8'h00;

    do_reset();
    check_reset_vals("rst");

    // CPU decode and prg_hi mux
    cpu_write(16'h8000, 8'h05);
    cpu_write(16'hC000, 8'hF3);
    check_banks("wr1", 4'h5, 4'h3);
    cpu_addr = 16'h8123;
    #1 chk("hi_a14_0", 8'(prg_hi), 8'h53);
    cpu_addr = 16'hC123;
    #1 chk("hi_a14_1", 8'(prg_hi), 8'h5F);
    cpu_write(16'h4000, 8'h09);
    check_banks("undec", 4'h5, 4'h3);

    // Outer lock
    cpu_write(16'h8000, 8'h0A);
    cpu_write(16'hBFFF, 8'h02);
    cpu_write(16'hC000, 8'h07);
    check_banks("lock", 4'hA, 4'h7);
    cpu_addr = 16'h8000;
    #1 chk("hi_lock", 8'(prg_hi), 8'h27);

    // Dump of {in=7, ou=3}, ready toggled 1,0,1; a start while busy is ignored
    do_reset();
    cpu_write(16'h8000, 8'h03);
    cpu_write(16'hC000, 8'h07);
    start_xfer(1'b0);
    chk("d_valid0", 8'(ss_valid), 8'h1);
    chk("d_busy0",  8'(ss_busy),  8'h1);
    chk("d_idx0",   ss_idx,       8'h00);
    chk("d_wdat0",  ss_wdat,      8'h73);
    ss_ready = 1'b1;
    tick();
    chk("d_idx1",   ss_idx,       8'h01);
    chk("d_wdat1",  ss_wdat,      8'h68);
    ss_ready = 1'b0;
    ss_start = 1'b1;
    ss_dir   = 1'b1;
    tick();
    ss_start = 1'b0;
    chk("d_hold",   ss_idx,       8'h01);
    chk("d_valid1", 8'(ss_valid), 8'h1);
    ss_ready = 1'b1;
    tick();
    ss_ready = 1'b0;
    chk("d_done",   8'(ss_done),  8'h1);
    chk("d_valid2", 8'(ss_valid), 8'h0);
    tick();
    chk("d_done_1", 8'(ss_done),  8'h0);
    chk("d_idle",   8'(ss_busy),  8'h0);
    check_banks("d_regs", 4'h3, 4'h7);

    // Good restore
    start_xfer(1'b1);
    ss_ready = 1'b1;
    ss_rdat  = 8'h21;
    tick();
    ss_rdat  = 8'h68;
    tick();
    ss_ready = 1'b0;
    chk("r_chk_busy", 8'(ss_busy), 8'h1);
    check_banks("r_pre", 4'h3, 4'h7);
    tick();
    tick();
    chk("r_done", 8'(ss_done), 8'h1);
    check_banks("r_commit", 4'h1, 4'h2);
    tick();
    chk("r_err", 8'(ss_err), 8'h0);
    chk("r_idle", 8'(ss_busy), 8'h0);

    // Rejected restore
    start_xfer(1'b1);
    ss_ready = 1'b1;
    ss_rdat  = 8'h21;
    tick();
    ss_rdat  = 8'h12;
    tick();
    ss_ready = 1'b0;
    tick();
    chk("bad_done", 8'(ss_done), 8'h1);
    chk("bad_err",  8'(ss_err),  8'h1);
    tick();
    check_banks("bad_regs", 4'h1, 4'h2);
    chk("bad_err_sticky", 8'(ss_err), 8'h1);

    // Restore with two CPU writes pending; the later one lands after the commit
    start_xfer(1'b1);
    chk("p_err_clr", 8'(ss_err), 8'h0);
    cpu_write(16'hC000, 8'h04);
    chk("p_ovf0", 8'(wr_ovf), 8'h0);
    cpu_write(16'hC000, 8'h09);
    chk("p_ovf1", 8'(wr_ovf), 8'h1);
    check_banks("p_held", 4'h1, 4'h2);
    ss_ready = 1'b1;
    ss_rdat  = 8'h51;
    tick();
    ss_rdat  = 8'h68;
    tick();
    ss_ready = 1'b0;
    tick();
    tick();
    chk("p_done", 8'(ss_done), 8'h1);
    check_banks("p_commit", 4'h1, 4'h5);
    tick();
    check_banks("p_cpu_wins", 4'h1, 4'h9);
    chk("p_ovf_sticky", 8'(wr_ovf), 8'h1);

    // Reset mid-transfer discards staged restore data
    start_xfer(1'b1);
    ss_ready = 1'b1;
    ss_rdat  = 8'hA6;
    tick();
    ss_ready = 1'b0;
    chk("x_mid_idx", ss_idx, 8'h01);
    map_rst = 1'b1;
    tick();
    map_rst = 1'b0;
    check_reset_vals("x_rst");
    for (int i = 0; i < 4; i++) tick();
    check_reset_vals("x_after");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/map104_bank_ctrl.md
Name: map104_bank_ctrl

Overview:
- Owns the PRG outer/inner bank registers of an outer-lock multicart mapper: 4-bit outer bank with lock bit, 4-bit inner bank.
- Arbitrates register writes between CPU bus writes and a save-state sequencer.
- Save-state sequencer serialises dump/restore of the register image over a valid/ready byte channel.
- Drives upper PRG address bits to the mapper top level; replaces the ad-hoc ss_act branch in the mapper register process.

Parameters:
- MAP_IDX, 8'd104: mapper index stored in save-state byte 1 and checked on restore.
- SS_BYTES, 2: number of save-state bytes sequenced; legal range 2..8. Bytes 2 and above read as 8'hFF and are ignored on restore.

Ports:
- m2  in  1  CPU M2 clock; all state updates on falling edge of m2.
- map_rst  in  1  synchronous, active-high reset, sampled on the m2 falling edge.
- cpu_addr  in  16  CPU address.
- cpu_dat  in  8  CPU write data.
- cpu_rw  in  1  1=read, 0=write.
- ss_start  in  1  one-cycle request to start a save-state transfer.
- ss_dir  in  1  0=dump, 1=restore; sampled with ss_start.
- ss_valid  out  1  byte transfer offered.
- ss_ready  in  1  partner accepts or provides a byte.
- ss_idx  out  8  current byte index.
- ss_wdat  out  8  dump data for ss_idx.
- ss_rdat  in  8  restore data; sampled on handshake.
- ss_busy  out  1  sequencer not idle.
- ss_done  out  1  one-cycle pulse when a transfer completes.
- ss_err  out  1  sticky; last restore rejected.
- wr_ovf  out  1  sticky; a pending CPU write was overwritten.
- prg_ou  out  4  outer bank register; bit3 = lock.
- prg_in  out  4  inner bank register.
- prg_hi  out  7  prg_addr[20:14].

Behaviour:
- Reset: prg_ou=0, prg_in=0, FSM=IDLE, ss_valid=0, ss_idx=0, ss_done=0, ss_err=0, wr_ovf=0, pending buffer empty. Reset aborts any transfer mid-operation; staged restore data is discarded.
- CPU decode, active when !cpu_rw:
  - (cpu_addr & C000)==8000 is an outer write, ignored if prg_ou[3]=1.
  - (cpu_addr & C000)==C000 is an inner write.
  - Data uses cpu_dat[3:0].
- prg_hi: cpu_addr[14]=0 -> {prg_ou[2:0], prg_in}; cpu_addr[14]=1 -> {prg_ou[2:0], 4'hF}. Combinational.
- Arbitration: in IDLE, CPU writes apply at the same edge (0 latency).
- While ss_busy, a decoded CPU write goes to a one-entry pending buffer (target, data). The outer lock is evaluated when the write is applied, not when it is captured.
- A second pending write replaces the first and sets wr_ovf.
- The pending write is applied on the edge after ss_done. After a restore, that is the edge after the commit, so the CPU wins over the restored image.
- FSM states: IDLE, XFER, CHECK, COMMIT, DONE.
  - IDLE: ss_start -> XFER; ss_idx=0; latch ss_dir; clear ss_err if restore.
  - XFER: ss_valid=1. On ss_valid & ss_ready:
    - dump: byte consumed.
    - restore: ss_rdat stored (byte0 -> stage, byte1 -> id_stage).
    - Then ss_idx+1. At ss_idx==SS_BYTES-1, go to CHECK if restore, else DONE.
    - ss_idx holds while !ss_ready; no timeout.
  - CHECK: id_stage==MAP_IDX -> COMMIT; otherwise set ss_err and go to DONE with no change.
  - COMMIT: {prg_in, prg_ou} <= stage, ignoring the lock; go to DONE.
  - DONE: ss_done=1 for one cycle; go to IDLE.
- ss_wdat: byte0 = {prg_in, prg_ou}, byte1 = MAP_IDX, others 8'hFF. Combinational from ss_idx.
- ss_start while busy is ignored.
- ss_busy=1 in every state except IDLE.
- CPU reads have no effect.

Decomposition:
- Shared package/defs holds:
  - FSM state encoding, 3-bit localparams.
  - Decode masks: 16'hC000, 16'h8000.
  - Save-state byte indices: SS_IDX_BANK=0, SS_IDX_MAP=1.
- One natural sub-module, map_wr_pend: the one-entry pending-write buffer with overwrite flag.

Test Plan:
- Reset, then write $8000<-$05 and $C000<-$03 -> prg_ou=5, prg_in=3; prg_hi=0x53 at A14=0, 0x5F at A14=1.
- Write $8000<-$0A (sets lock), then $8000<-$02 -> prg_ou stays A; $C000<-$07 still gives prg_in=7.
- Dump with ss_ready toggled 1,0,1 -> ss_wdat sequence 0x73 at idx0, 0x68 at idx1; ss_done pulses once; registers unchanged.
- Restore with rdat 0x21, 0x68 -> after COMMIT prg_ou=1, prg_in=2, ss_err=0. Repeat with 0x21, 0x12 -> registers unchanged, ss_err=1.
- During restore, CPU writes $C000<-$04 then $C000<-$09 -> wr_ovf=1; after ss_done prg_in=9 (CPU wins over restored value).
- Assert map_rst mid-XFER of a restore -> all outputs at reset values, FSM IDLE, staged data not committed.
